bus_access_unit: RTL and testbench
==================================

Name: bus_access_unit

Overview:
- Front-end bus master sitting directly upstream of the back-end peripheral unit; converts single CPU load/store requests into the one-hot select / write-strobe / address / data bus that unit consumes.
- Decodes the address, sequences wait states for synchronous-read targets (data RAM, keyboard), captures read data, and stalls the CPU until the transaction completes.

Parameters:
- RD_WAIT, 1, bus cycles select is held on a read before read data is sampled (legal 1..7).
- PERIPH_MASK, 32'h0000_000F, bit i set = peripheral select index i is mapped (0 LED, 1 segment, 2 keyboard, 3 VGA); bit 31 is ignored.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  request valid; held by CPU until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid with cpu_ack, held until next ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ack: unmapped address
- cpu_stall  out  1  combinational: (state==IDLE & cpu_req) | (state!=IDLE & !cpu_ack)
- select  out  32  one-hot target select, registered
- FEPU_BEPU_w  out  1  write strobe, registered
- FEPU_BEPU_addr  out  32  registered copy of cpu_addr
- FEPU_BEPU_data  out  32  registered store data; 0 on loads
- BEPU_FEPU_data  in  32  read data from back end

Behaviour:
- Reset: synchronous; clk is the only clock. All outputs 0, state IDLE, wait counter 0; a transaction in flight is abandoned with no write strobe and no ack.
- Decode, performed on the latched address:
  - cpu_addr[31]=0 -> select[31] (data RAM; upper bits alias).
  - cpu_addr[31]=1 -> idx = cpu_addr[12:8]. Valid when PERIPH_MASK[idx]=1 and idx!=31; then select[idx]=1. Otherwise unmapped.
- FSM states IDLE, ACCESS, WAIT, DONE, ERR.
  - IDLE: on cpu_req=1, latch we/addr/wdata.
    - Mapped: go to ACCESS; select, addr and data are registered so they are valid in the next cycle.
    - Unmapped: go to ERR; no bus activity.
  - ACCESS, store: FEPU_BEPU_w=1 for exactly this one cycle, then DONE.
  - ACCESS, load: w=0; if RD_WAIT=1, sample BEPU_FEPU_data at the end of this cycle and go to DONE; else go to WAIT.
  - WAIT: select held; counter counts to RD_WAIT-1, then sample and go to DONE.
  - DONE: select, w and data cleared to 0; cpu_ack=1; cpu_rdata updated on loads, unchanged on stores; then IDLE.
  - ERR: cpu_ack=1, cpu_err=1, cpu_rdata=0; then IDLE.
- Latency, request cycle = cycle 0:
  - Store: bus cycle 1, ack cycle 2.
  - Load: bus cycles 1..RD_WAIT, ack cycle RD_WAIT+1.
  - Unmapped: ack cycle 1.
- Select is one-hot or all-zero; never more than one bit set. Select is 0 in IDLE, DONE and ERR.
- cpu_req is sampled only in IDLE. A request still high in the ack cycle is not a new request; a held req starts the next transaction in the cycle after ack (cycle 3 for back-to-back stores).
- Changes to cpu_addr, cpu_we or cpu_wdata during a transaction are ignored (latched copy is used).
- cpu_err=0 whenever cpu_ack=0.

Test Plan:
- Reset, then store addr 0xFFFF_0000 data 0x0000_00A5 -> cycle 1: select=0x0000_0001, w=1, data=0xA5; cycle 2: ack=1, err=0, select=0; w high exactly 1 cycle.
- Load addr 0x0000_0014 with BEPU_FEPU_data=0xDEAD_BEEF, RD_WAIT=1 -> select=0x8000_0000 in cycle 1, FEPU_BEPU_data=0; ack cycle 2 with rdata=0xDEAD_BEEF; stall high cycles 0-1.
- RD_WAIT=3, load addr 0xFFFF_0200 (keyboard), BEPU_FEPU_data=0x0000_001C -> select=0x0000_0004 for cycles 1-3; ack cycle 4 with rdata=0x1C.
- Load addr 0xFFFF_0500 (idx 5 unmapped) -> ack+err cycle 1, rdata=0, select stays 0, w never asserted.
- Hold req across two stores (0xFFFF_0100/0x12, then 0xFFFF_0300/0x41) -> ack cycles 2 and 5, w pulses in cycles 1 and 4, selects 0x2 then 0x8.
- Assert rst in cycle 1 of a store -> cycle 2: all outputs 0, no ack, state IDLE; a fresh request then completes normally.

Source files
------------

// File: rtl/bus_access_unit_if.sv
// bus_access_unit_if: CPU request/response and front-end to back-end peripheral bus signals
interface bus_access_unit_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_stall;
  logic [31:0] select;
  logic        FEPU_BEPU_w;
  logic [31:0] FEPU_BEPU_addr;
  logic [31:0] FEPU_BEPU_data;
  logic [31:0] BEPU_FEPU_data;
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, BEPU_FEPU_data,
    output cpu_rdata, cpu_ack, cpu_err, cpu_stall, select, FEPU_BEPU_w, FEPU_BEPU_addr, FEPU_BEPU_data
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, BEPU_FEPU_data,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_stall, select, FEPU_BEPU_w, FEPU_BEPU_addr, FEPU_BEPU_data
  );
endinterface

// File: rtl/bus_access_unit.sv
// bus_access_unit: turns single CPU load/store requests into one-hot select bus cycles with read wait states
module bus_access_unit #(
  parameter int          RD_WAIT     = 1,
  parameter logic [31:0] PERIPH_MASK = 32'h0000_000F
) (
  input logic clk,
  input logic rst,
  bus_access_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} state_t;
  state_t      state_q;
  logic        we_q;
  logic [2:0]  cnt_q;
  logic [31:0] rdata_q, sel_q, addr_q, data_q;
  logic        ack_q, err_q, w_q;
  logic [4:0]  idx;
  logic        mapped;
  logic [31:0] sel_d;
  // Address decode: low half is data RAM, high half picks a peripheral by addr[12:8]; index 31 is reserved for RAM
  assign idx    = bus.cpu_addr[12:8];
  assign mapped = !bus.cpu_addr[31] || (PERIPH_MASK[idx] && idx != 5'd31);
  assign sel_d  = bus.cpu_addr[31] ? 32'd1 << idx : 32'h8000_0000;
  assign bus.cpu_stall      = (state_q == IDLE && bus.cpu_req) || (state_q != IDLE && !ack_q);
  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_ack        = ack_q;
  assign bus.cpu_err        = err_q;
  assign bus.select         = sel_q;
  assign bus.FEPU_BEPU_w    = w_q;
  assign bus.FEPU_BEPU_addr = addr_q;
  assign bus.FEPU_BEPU_data = data_q;
  // Transaction sequencer; every bus and CPU output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cpu_req) begin
          we_q <= bus.cpu_we;
          if (mapped) begin
            state_q <= ACCESS;
            sel_q   <= sel_d;
            addr_q  <= bus.cpu_addr;
            w_q     <= bus.cpu_we;
            data_q  <= bus.cpu_we ? bus.cpu_wdata : 32'd0;
          end else begin
            state_q <= ERR;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          w_q <= 1'b0;
          if (we_q || RD_WAIT == 1) begin
            state_q <= DONE;
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b1;
            rdata_q <= we_q ? rdata_q : bus.BEPU_FEPU_data;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 3'd1;
          end
        end
        WAIT: if (cnt_q == 3'(RD_WAIT - 1)) begin
          state_q <= DONE;
          cnt_q   <= '0;
          sel_q   <= '0;
          data_q  <= '0;
          ack_q   <= 1'b1;
          rdata_q <= bus.BEPU_FEPU_data;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_access_unit.sv
// tb_bus_access_unit: randomized transaction-level check of two bus_access_unit builds (RD_WAIT 1 and 3)
module tb_bus_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic which = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bepu = '0;
  int cmp = 0, errs = 0;
  logic [31:0] exp_rd [2];
  always #5 clk = ~clk;
  bus_access_unit_if b1 ();
  bus_access_unit_if b3 ();
  assign b1.cpu_req = req && !which;
  assign b3.cpu_req = req && which;
  assign b1.cpu_we = we;
  assign b3.cpu_we = we;
  assign b1.cpu_addr = addr;
  assign b3.cpu_addr = addr;
  assign b1.cpu_wdata = wdata;
  assign b3.cpu_wdata = wdata;
  assign b1.BEPU_FEPU_data = bepu;
  assign b3.BEPU_FEPU_data = bepu;
  bus_access_unit #(.RD_WAIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  bus_access_unit #(.RD_WAIT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  logic        o_ack, o_err, o_stall, o_w;
  logic [31:0] o_sel, o_fdata, o_faddr, o_rdata;
  assign o_ack   = which ? b3.cpu_ack : b1.cpu_ack;
  assign o_err   = which ? b3.cpu_err : b1.cpu_err;
  assign o_stall = which ? b3.cpu_stall : b1.cpu_stall;
  assign o_w     = which ? b3.FEPU_BEPU_w : b1.FEPU_BEPU_w;
  assign o_sel   = which ? b3.select : b1.select;
  assign o_fdata = which ? b3.FEPU_BEPU_data : b1.FEPU_BEPU_data;
  assign o_faddr = which ? b3.FEPU_BEPU_addr : b1.FEPU_BEPU_addr;
  assign o_rdata = which ? b3.cpu_rdata : b1.cpu_rdata;

  // One whole transaction on the selected DUT, expectations derived from the address map and latency rules
  task automatic run_txn(input logic w_i, input logic [31:0] a, input logic [31:0] d, input logic hold, input string nm);
    logic [31:0] mask = 32'h0000_000F;
    int          rw = which ? 3 : 1;
    logic        mapped = !a[31] || (mask[a[12:8]] && a[12:8] != 5'd31);
    logic [31:0] esel = a[31] ? 32'd1 << a[12:8] : 32'h8000_0000;
    int          lat = !mapped ? 1 : (w_i ? 2 : rw + 1);
    logic [31:0] sampled = '0;
    logic [99:0] got, want;
    req = 1'b1; we = w_i; addr = a; wdata = d; bepu = $urandom;
    #1;
    got  = {o_ack, o_err, o_stall, o_w, o_sel, o_fdata, o_rdata};
    want = {1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, exp_rd[which]};
    cmp++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s cyc0 {ack,err,stall,w,sel,fdata,rdata}: got %h want %h", nm, got, want);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      we = 1'($urandom); addr = $urandom; wdata = $urandom; bepu = $urandom;
      if (k == lat) req = hold;
      if (k == rw) sampled = bepu;
      #1;
      got = {o_ack, o_err, o_stall, o_w, o_sel, o_fdata, o_rdata};
      if (k < lat) begin
        want = {1'b0, 1'b0, 1'b1, w_i && k == 1, esel, w_i ? d : 32'd0, exp_rd[which]};
        cmp++;
        if (o_faddr !== a) begin
          errs++;
          $display("FAIL %s cyc%0d bus_addr: got %h want %h", nm, k, o_faddr, a);
        end
      end else begin
        exp_rd[which] = !mapped ? 32'd0 : (w_i ? exp_rd[which] : sampled);
        want = {1'b1, !mapped, 1'b0, 1'b0, 32'd0, 32'd0, exp_rd[which]};
      end
      cmp++;
      if (got !== want) begin
        errs++;
        $display("FAIL %s cyc%0d {ack,err,stall,w,sel,fdata,rdata}: got %h want %h", nm, k, got, want);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    cmp++;
    if ({b1.cpu_ack, b1.cpu_err, b1.cpu_stall, b1.FEPU_BEPU_w, b1.select, b1.FEPU_BEPU_addr, b1.FEPU_BEPU_data, b1.cpu_rdata} !== 132'd0) begin
      errs++;
      $display("FAIL reset_u1: got sel %h rdata %h ack %b want all zero", b1.select, b1.cpu_rdata, b1.cpu_ack);
    end
    cmp++;
    if ({b3.cpu_ack, b3.cpu_err, b3.cpu_stall, b3.FEPU_BEPU_w, b3.select, b3.FEPU_BEPU_addr, b3.FEPU_BEPU_data, b3.cpu_rdata} !== 132'd0) begin
      errs++;
      $display("FAIL reset_u3: got sel %h rdata %h ack %b want all zero", b3.select, b3.cpu_rdata, b3.cpu_ack);
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store;
    which = 1'b0;
    run_txn(1'b1, 32'hFFFF_0000, 32'h0000_00A5, 1'b0, "store_led");
    run_txn(1'b1, 32'h0000_1234, 32'hCAFE_F00D, 1'b0, "store_ram");
    which = 1'b1;
    run_txn(1'b1, 32'hFFFF_0300, 32'h0BAD_0001, 1'b0, "store_vga_u3");
  endtask

  task automatic test_load;
    which = 1'b0;
    run_txn(1'b0, 32'h0000_0014, 32'h0, 1'b0, "load_ram");
    run_txn(1'b0, 32'hFFFF_0100, 32'h0, 1'b0, "load_seg");
  endtask

  task automatic test_wait_load;
    which = 1'b1;
    run_txn(1'b0, 32'hFFFF_0200, 32'h0, 1'b0, "load_kbd_wait");
    run_txn(1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, "load_ram_wait");
  endtask

  task automatic test_unmapped;
    which = 1'b0;
    run_txn(1'b0, 32'hFFFF_0500, 32'h0, 1'b0, "unmapped_idx5");
    run_txn(1'b1, 32'hFFFF_1F00, 32'h55, 1'b0, "unmapped_idx31");
    which = 1'b1;
    run_txn(1'b0, 32'h8000_0400, 32'h0, 1'b0, "unmapped_idx4_u3");
  endtask

  task automatic test_back_to_back;
    which = 1'b0;
    run_txn(1'b1, 32'hFFFF_0100, 32'h12, 1'b1, "b2b_first");
    run_txn(1'b1, 32'hFFFF_0300, 32'h41, 1'b1, "b2b_second");
    run_txn(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, "b2b_load");
  endtask

  task automatic test_reset_mid;
    which = 1'b0;
    req = 1'b1; we = 1'b1; addr = 32'hFFFF_0100; wdata = 32'h77;
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp++;
    if (o_sel !== 32'h2 || o_w !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_pre: got sel %h w %b want 00000002 1", o_sel, o_w);
    end
    @(negedge clk);
    req = 1'b0;
    #1;
    cmp++;
    if ({o_ack, o_err, o_stall, o_w, o_sel, o_faddr, o_fdata, o_rdata} !== 132'd0) begin
      errs++;
      $display("FAIL rst_mid_post: got ack %b w %b sel %h addr %h want all zero", o_ack, o_w, o_sel, o_faddr);
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 32'hFFFF_0000, 32'h3C, 1'b0, "rst_mid_fresh");
  endtask

  task automatic test_random;
    logic        hold = 1'b0;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      if (!hold) which = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[12:8] = 5'($urandom_range(0, 5));
      hold = (i == 39) ? 1'b0 : 1'($urandom);
      run_txn(1'($urandom), a, $urandom, hold, "random");
    end
  endtask

  initial begin
    exp_rd[0] = '0; exp_rd[1] = '0;
    test_reset;
    test_store;
    test_load;
    test_wait_load;
    test_unmapped;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
